// File: rtl/ysyx_24110006_alu_arb_if.sv
// Requester channel of the ALU arbiter: one request (operands + op) and one response (result + branch).
// The requester uses the master modport; the arbiter uses the slave modport.
interface ysyx_24110006_alu_arb_if #(
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [6:0]        req_op;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_r;
    logic              resp_branch;

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready,
        input  req_ready, resp_valid, resp_r, resp_branch
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready,
        output req_ready, resp_valid, resp_r, resp_branch
    );
endinterface

// File: rtl/ysyx_24110006_alu_arb.sv
// Round-robin sequencer sharing one combinational ALU between two requesters (IDLE -> EXEC -> RESP).
// Optional perf counters are enabled by defining ALU_ARB_PERF_EN; otherwise the perf ports read 0.
module ysyx_24110006_alu_arb #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    ysyx_24110006_alu_arb_if.slave req0,
    ysyx_24110006_alu_arb_if.slave req1,
    output logic [DATA_W-1:0]      o_alu_a,
    output logic [DATA_W-1:0]      o_alu_b,
    output logic                   o_alu_sub,
    output logic                   o_alu_sign,
    output logic                   o_alu_sra,
    output logic [3:0]             o_alu_t,
    input  logic [DATA_W-1:0]      i_alu_r,
    input  logic                   i_alu_branch,
    output logic [CNT_W-1:0]       o_perf_grant0,
    output logic [CNT_W-1:0]       o_perf_grant1,
    output logic [CNT_W-1:0]       o_perf_conflict
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              prio_q, prio_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [6:0]        op_q, op_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic              br_q, br_d;
    logic              gnt0, gnt1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            r_q     <= r_d;
            br_q    <= br_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        r_d     = r_q;
        br_d    = br_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        case (state_q)
            S_IDLE: begin
                // prio only breaks ties; a lone requester always wins
                gnt0 = req0.req_valid && (!req1.req_valid || !prio_q);
                gnt1 = req1.req_valid && (!req0.req_valid ||  prio_q);
                if (gnt0) begin
                    a_d     = req0.req_a;
                    b_d     = req0.req_b;
                    op_d    = req0.req_op;
                    owner_d = 1'b0;
                    state_d = S_EXEC;
                end else if (gnt1) begin
                    a_d     = req1.req_a;
                    b_d     = req1.req_b;
                    op_d    = req1.req_op;
                    owner_d = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                r_d     = i_alu_r;
                br_d    = i_alu_branch;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (owner_q ? req1.resp_ready : req0.resp_ready) begin
                    prio_d  = ~owner_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req0.req_ready   = gnt0;
    assign req1.req_ready   = gnt1;
    assign req0.resp_valid  = (state_q == S_RESP) && !owner_q;
    assign req1.resp_valid  = (state_q == S_RESP) &&  owner_q;
    assign req0.resp_r      = r_q;
    assign req1.resp_r      = r_q;
    assign req0.resp_branch = br_q;
    assign req1.resp_branch = br_q;

    // ALU inputs come only from the latched op, so they stay quiet outside EXEC
    assign o_alu_a    = a_q;
    assign o_alu_b    = b_q;
    assign o_alu_sra  = op_q[6];
    assign o_alu_sign = op_q[5];
    assign o_alu_sub  = op_q[4];
    assign o_alu_t    = op_q[3:0];

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] grant0_q, grant1_q, conflict_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            grant0_q   <= '0;
            grant1_q   <= '0;
            conflict_q <= '0;
        end else begin
            if (gnt0) grant0_q <= grant0_q + CNT_W'(1);
            if (gnt1) grant1_q <= grant1_q + CNT_W'(1);
            if ((state_q == S_IDLE) && req0.req_valid && req1.req_valid)
                conflict_q <= conflict_q + CNT_W'(1);
        end
    end

    assign o_perf_grant0   = grant0_q;
    assign o_perf_grant1   = grant1_q;
    assign o_perf_conflict = conflict_q;
`else
    assign o_perf_grant0   = '0;
    assign o_perf_grant1   = '0;
    assign o_perf_conflict = '0;
`endif
endmodule

// File: tb/tb_ysyx_24110006_alu_arb.sv
// Directed bench for ysyx_24110006_alu_arb with a small behavioural ALU on the ALU-side ports.
// Perf expectations follow ALU_ARB_PERF_EN (counters) or its absence (tied to 0).
module tb_ysyx_24110006_alu_arb;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] alu_a, alu_b, alu_r;
    logic        alu_sub, alu_sign, alu_sra, alu_br;
    logic [3:0]  alu_t;
    logic [31:0] perf_g0, perf_g1, perf_cf;
    int          passed = 0;
    int          total  = 0;

    ysyx_24110006_alu_arb_if #(.DATA_W(32)) rq0 ();
    ysyx_24110006_alu_arb_if #(.DATA_W(32)) rq1 ();

    ysyx_24110006_alu_arb #(.DATA_W(32), .CNT_W(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .req0            (rq0),
        .req1            (rq1),
        .o_alu_a         (alu_a),
        .o_alu_b         (alu_b),
        .o_alu_sub       (alu_sub),
        .o_alu_sign      (alu_sign),
        .o_alu_sra       (alu_sra),
        .o_alu_t         (alu_t),
        .i_alu_r         (alu_r),
        .i_alu_branch    (alu_br),
        .o_perf_grant0   (perf_g0),
        .o_perf_grant1   (perf_g1),
        .o_perf_conflict (perf_cf)
    );

    always #5 clock = ~clock;

    // ALU stand-in covering the ops exercised below
    always_comb begin
        alu_r  = '0;
        alu_br = 1'b0;
        case (alu_t)
            4'h0: alu_r  = alu_sub ? (alu_a - alu_b) : (alu_a + alu_b);
            4'h8: alu_br = (alu_a == alu_b);
            4'hC: alu_br = ($signed(alu_a) < $signed(alu_b));
            4'hE: alu_br = (alu_a < alu_b);
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] op);
        if (n == 0) begin
            rq0.req_valid = v; rq0.req_a = a; rq0.req_b = b; rq0.req_op = op;
        end else begin
            rq1.req_valid = v; rq1.req_a = a; rq1.req_b = b; rq1.req_op = op;
        end
    endtask

    // One uncontended transaction on requester n, resp_ready assumed high
    task automatic run1(input int n, input logic [31:0] a, input logic [31:0] b, input logic [6:0] op,
                        input logic [31:0] er, input logic eb, input bit cr, input string tag);
        set_req(n, 1'b1, a, b, op);
        #1;
        chk({tag, "_ready"}, (n == 0) ? rq0.req_ready : rq1.req_ready, 32'd1);
        tick();
        set_req(n, 1'b0, a, b, op);
        chk({tag, "_exec_nores"}, {31'd0, rq0.resp_valid | rq1.resp_valid}, 32'd0);
        chk({tag, "_alu_a"}, alu_a, a);
        tick();
        chk({tag, "_resp_own"}, (n == 0) ? rq0.resp_valid : rq1.resp_valid, 32'd1);
        chk({tag, "_resp_oth"}, (n == 0) ? rq1.resp_valid : rq0.resp_valid, 32'd0);
        if (cr) chk({tag, "_r"}, (n == 0) ? rq0.resp_r : rq1.resp_r, er);
        chk({tag, "_branch"}, (n == 0) ? rq0.resp_branch : rq1.resp_branch, {31'd0, eb});
        tick();
        chk({tag, "_resp_done"}, (n == 0) ? rq0.resp_valid : rq1.resp_valid, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Both requesters valid continuously for four grants: expect 0,1,0,1
    task automatic contend4(input string tag);
        set_req(0, 1'b1, 32'd1, 32'd1, 7'h00);
        set_req(1, 1'b1, 32'd10, 32'd20, 7'h00);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("%s_rdy0_%0d", tag, i), rq0.req_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("%s_rdy1_%0d", tag, i), rq1.req_ready, (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            tick();
            chk($sformatf("%s_v0_%0d", tag, i), rq0.resp_valid, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("%s_v1_%0d", tag, i), rq1.resp_valid, (i % 2 == 1) ? 32'd1 : 32'd0);
            chk($sformatf("%s_r_%0d", tag, i), (i % 2 == 0) ? rq0.resp_r : rq1.resp_r,
                (i % 2 == 0) ? 32'd2 : 32'd30);
            tick();
        end
        rq0.req_valid = 1'b0;
        rq1.req_valid = 1'b0;
    endtask

    initial begin
        set_req(0, 1'b0, 32'd0, 32'd0, 7'h00);
        set_req(1, 1'b0, 32'd0, 32'd0, 7'h00);
        rq0.resp_ready = 1'b1;
        rq1.resp_ready = 1'b1;
        do_reset();

        // Reset state
        #1;
        chk("rst_ready0", rq0.req_ready, 32'd0);
        chk("rst_ready1", rq1.req_ready, 32'd0);
        chk("rst_resp0", rq0.resp_valid, 32'd0);
        chk("rst_resp1", rq1.resp_valid, 32'd0);
        chk("rst_r", rq0.resp_r, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_t", {28'd0, alu_t}, 32'd0);
        chk("rst_perf_g0", perf_g0, 32'd0);

        // ADD, SUB, BEQ on req0
        run1(0, 32'd5, 32'd3, 7'h00, 32'd8, 1'b0, 1'b1, "add");
        run1(0, 32'd5, 32'd3, 7'h10, 32'd2, 1'b0, 1'b1, "sub");
        run1(0, 32'd7, 32'd7, 7'h18, 32'd0, 1'b1, 1'b0, "beq");
        chk("hold_alu_a", alu_a, 32'd7);

        // Fair alternation after reset
        do_reset();
        contend4("rr");

        // Back-pressure on resp0 while req1 waits
        rq0.resp_ready = 1'b0;
        set_req(0, 1'b1, 32'd9, 32'd4, 7'h10);
        #1;
        chk("bp_ready0", rq0.req_ready, 32'd1);
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 7'h00);
        set_req(1, 1'b1, 32'd100, 32'd1, 7'h00);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_v0_%0d", i), rq0.resp_valid, 32'd1);
            chk($sformatf("bp_r_%0d", i), rq0.resp_r, 32'd5);
            chk($sformatf("bp_rdy1_%0d", i), rq1.req_ready, 32'd0);
            tick();
        end
        rq0.resp_ready = 1'b1;
        #1;
        chk("bp_rdy1_release", rq1.req_ready, 32'd0);
        tick();
        run1(1, 32'd100, 32'd1, 7'h00, 32'd101, 1'b0, 1'b1, "bp_req1");

        // Signed vs unsigned less-than on the same operands
        run1(0, 32'hFFFF_FFFF, 32'd1, 7'h3C, 32'd0, 1'b1, 1'b0, "blt");
        run1(0, 32'hFFFF_FFFF, 32'd1, 7'h1E, 32'd0, 1'b0, 1'b0, "bltu");

        // Reset while the op is in EXEC
        set_req(0, 1'b1, 32'd3, 32'd4, 7'h00);
        #1;
        tick();
        set_req(0, 1'b0, 32'd0, 32'd0, 7'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_resp0", rq0.resp_valid, 32'd0);
        chk("mid_resp1", rq1.resp_valid, 32'd0);
        chk("mid_r", rq0.resp_r, 32'd0);
        chk("mid_alu_a", alu_a, 32'd0);
        chk("mid_alu_sub", {31'd0, alu_sub}, 32'd0);
        tick();
        chk("mid_no_resp", rq0.resp_valid, 32'd0);
        contend4("post");
`ifdef ALU_ARB_PERF_EN
        chk("perf_g0", perf_g0, 32'd2);
        chk("perf_g1", perf_g1, 32'd2);
        chk("perf_cf", perf_cf, 32'd4);
`else
        chk("perf_g0", perf_g0, 32'd0);
        chk("perf_g1", perf_g1, 32'd0);
        chk("perf_cf", perf_cf, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
